icache_refill: RTL
==================

Name: icache_refill

Overview:
- Memory-side responder for the instruction cache's miss interface.
- Accepts a halfword refill request (address plus valid) and obtains the shared byte-wide RAM port through the memory arbiter.
- Reads two consecutive bytes, then returns the little-endian halfword on rewrite_data with a one-cycle write_enable pulse.
- Sits between the instruction cache and the memory arbiter in the instruction-fetch path.

Parameters:
- ADDR_WIDTH, 32, width of request and RAM addresses.
- STALE_DROP, 1, if 1, a response whose latched address no longer matches a valid live request is discarded.

Ports:
- clk_in  input  1  system clock; all state changes on the rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global ready; when 0, all state, counters and outputs hold.
- flush_in  input  1  pipeline flush (mispredict); aborts any refill in progress.
- req_valid  input  1  instruction cache miss pending (top level drives it as !cache_hit).
- req_addr  input  ADDR_WIDTH  halfword address requested by the cache; bit 0 is ignored.
- mem_req  output  1  request to the arbiter for the RAM port.
- mem_gnt  input  1  arbiter grant; held high by the arbiter while mem_req=1.
- mem_a  output  ADDR_WIDTH  RAM byte address.
- mem_wr  output  1  RAM write strobe; constant 0.
- mem_din  input  8  RAM read byte; valid one cycle after its address is presented.
- rewrite_data  output  32  {16'b0, hi_byte, lo_byte}.
- write_enable  output  1  one-cycle strobe; the cache stores rewrite_data[15:0].
- busy_out  output  1  high in every state except IDLE.

Behaviour:
- States: IDLE, REQ, B0, B1, RESP (3-bit state register).
- Reset values (asynchronous on rst_n_in=0): state=IDLE; latched addr=0; lo/hi bytes=0; mem_req=0; mem_a=0; mem_wr=0; rewrite_data=0; write_enable=0; busy_out=0.
- IDLE: if req_valid, latch {req_addr[ADDR_WIDTH-1:1],1'b0} and go to REQ.
- REQ: mem_req=1. When mem_gnt=1, drive mem_a=addr (combinational) and go to B0. Otherwise stay in REQ.
- B0: mem_req=1; mem_a=addr+1 (wraps modulo 2^ADDR_WIDTH); capture lo=mem_din; go to B1.
- B1: mem_req=1; mem_a=0; capture hi=mem_din; go to RESP.
- RESP:
  - mem_req=0; rewrite_data={16'b0,hi,lo}.
  - write_enable=1 if STALE_DROP=0, or if req_valid=1 and req_addr[ADDR_WIDTH-1:1] equals the latched address bits. Otherwise write_enable=0 and the data is dropped.
  - Next state is IDLE.
- mem_a=0 whenever not actively addressing.
- rewrite_data holds its last value outside RESP; write_enable is 0 outside RESP.
- Latency: with mem_gnt already high, req_valid in cycle 0 gives write_enable in cycle 4.
- Back-to-back requests: after RESP the block spends one cycle in IDLE before the next REQ. This bubble gives the cache time to update cache_hit.
- flush_in=1 (when rdy_in=1): next state is IDLE from any state, and write_enable is forced 0 in that cycle. flush_in has priority over all transitions. An abandoned RAM read is harmless.
- mem_gnt falling in B0 or B1 (protocol violation): return to REQ and restart the read from byte 0.
- rdy_in=0: hold state, latched address and bytes; outputs keep their values. This includes write_enable if the block is in RESP; the cache's own rdy gating ignores it.
- Reset asserted mid-operation: immediate return to IDLE with mem_req=0 and no write_enable.
- Deassertion of rst_n_in is synchronised externally; the block does not need to synchronise it.

Test Plan:
- Basic refill:
  - Stimulus: mem_gnt tied 1; RAM[0x100]=0x13, RAM[0x101]=0x05; req_addr=0x100, req_valid=1.
  - Required: mem_a=0x100 in cycle 1 and 0x101 in cycle 2; write_enable=1 in cycle 4 only; rewrite_data=0x00000513; mem_wr=0 throughout.
- Grant delay:
  - Stimulus: mem_gnt held 0 for 5 cycles after mem_req rises.
  - Required: block stays in REQ with mem_a=0; reads begin on the first cycle with mem_gnt=1; data is correct.
- Stale drop:
  - Stimulus: request 0x200, then req_addr changes to 0x204 during B1.
  - Required: write_enable=0 in RESP; block returns to IDLE, then serves 0x204.
- Flush in B0:
  - Stimulus: flush_in=1 while in B0.
  - Required: IDLE on the next edge; mem_req=0; no write_enable.
- Pause:
  - Stimulus: rdy_in=0 for 3 cycles while in B1.
  - Required: state, mem_a and the lo byte are frozen; the correct halfword is returned after rdy_in returns to 1.
- Wrap and reset:
  - Stimulus: req_addr=0xFFFFFFFE gives byte addresses 0xFFFFFFFE and 0xFFFFFFFF. Separately, pulse rst_n_in=0 in REQ.
  - Required: the wrap case completes normally. The reset immediately drives mem_req=0 and busy_out=0, independent of clk_in.

Source files
------------

// File: rtl/icache_refill.sv
// Instruction-cache miss responder: fetches two consecutive bytes through the
// memory arbiter and returns them as a little-endian halfword with a write pulse.
module icache_refill #(
  parameter int ADDR_WIDTH = 32,
  parameter bit STALE_DROP = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  flush_in,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic [7:0]            mem_din,
  output logic [31:0]           rewrite_data,
  output logic                  write_enable,
  output logic                  busy_out
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    B0   = 3'd2,
    B1   = 3'd3,
    RESP = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              lo_q, lo_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0]   addr_hi_s;
  logic                    match_s;
  logic                    unused_req_bit0;

  // The request's byte lane is irrelevant: the block always fetches an aligned halfword.
  assign unused_req_bit0 = req_addr[0];
  assign addr_hi_s       = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  assign match_s         = req_valid && (req_addr[ADDR_WIDTH-1:1] == addr_q[ADDR_WIDTH-1:1]);

  // Next-state and datapath capture; everything holds while rdy_in is low.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lo_d    = lo_q;
    rdata_d = rdata_q;
    if (rdy_in) begin
      if (flush_in) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (req_valid) begin
              addr_d  = {req_addr[ADDR_WIDTH-1:1], 1'b0};
              state_d = REQ;
            end else begin
              state_d = IDLE;
            end
          end
          REQ: begin
            if (mem_gnt) state_d = B0;
            else         state_d = REQ;
          end
          // A grant lost mid-read restarts the fetch from the low byte.
          B0: begin
            if (mem_gnt) begin
              lo_d    = mem_din;
              state_d = B1;
            end else begin
              state_d = REQ;
            end
          end
          B1: begin
            if (mem_gnt) begin
              rdata_d = {16'h0000, mem_din, lo_q};
              state_d = RESP;
            end else begin
              state_d = REQ;
            end
          end
          RESP:    state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      addr_q  <= {ADDR_WIDTH{1'b0}};
      lo_q    <= 8'h00;
      rdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
    end
  end

  // Output decode; mem_a follows the grant combinationally so the first byte
  // address reaches the RAM in the same cycle the grant arrives.
  always_comb begin
    mem_req      = (state_q == REQ) || (state_q == B0) || (state_q == B1);
    busy_out     = (state_q != IDLE);
    mem_wr       = 1'b0;
    rewrite_data = rdata_q;
    if ((state_q == REQ) && mem_gnt) begin
      mem_a = addr_q;
    end else if (state_q == B0) begin
      mem_a = addr_hi_s;
    end else begin
      mem_a = {ADDR_WIDTH{1'b0}};
    end
    if ((state_q == RESP) && !(rdy_in && flush_in) && (!STALE_DROP || match_s)) begin
      write_enable = 1'b1;
    end else begin
      write_enable = 1'b0;
    end
  end

endmodule
